// File: rtl/tatzel_sar_ctrl_if.sv
// Handshake/data bundle between the SAR controller and its environment.
// The controller is built with the slave modport; the driver of ena/start/cmp_in uses master.
interface tatzel_sar_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             ena;
  logic             start;
  logic             cmp_in;
  logic [WIDTH-1:0] dac_code;
  logic [WIDTH-1:0] result;
  logic             busy;
  logic             done;

  modport master (
    output ena, start, cmp_in,
    input  dac_code, result, busy, done
  );

  modport slave (
    input  ena, start, cmp_in,
    output dac_code, result, busy, done
  );
endinterface

// File: rtl/tatzel_sar_ctrl.sv
// Successive-approximation controller: trial codes to the DAC trim, comparator read-back.
// Define TATZEL_SAR_AVG_EN to average four back-to-back conversions per start.
module tatzel_sar_ctrl #(
  parameter int WIDTH         = 8,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  tatzel_sar_ctrl_if.slave  sar
);

  localparam int KW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [KW-1:0]    K_MSB    = KW'(WIDTH - 1);
  localparam logic [3:0]       CNT_LOAD = 4'(SETTLE_CYCLES - 1);
  localparam logic [WIDTH-1:0] MSB_CODE = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    DECIDE,
    FINISH
  } state_t;

  state_t           state, state_n;
  logic             cmp_meta, cmp_s;
  logic [KW-1:0]    k, k_n;
  logic [3:0]       cnt, cnt_n;
  logic [WIDTH-1:0] dac_code, dac_n;
  logic [WIDTH-1:0] result, result_n;
  logic [WIDTH-1:0] dec_code;

`ifdef TATZEL_SAR_AVG_EN
  logic [WIDTH+1:0] acc, acc_n, sum;
  logic [1:0]       conv, conv_n;
`endif

  // Comparator output is asynchronous to clk; only cmp_s feeds the decision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmp_meta <= 1'b0;
      cmp_s    <= 1'b0;
    end else begin
      cmp_meta <= sar.cmp_in;
      cmp_s    <= cmp_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      k        <= '0;
      cnt      <= '0;
      dac_code <= '0;
      result   <= '0;
`ifdef TATZEL_SAR_AVG_EN
      acc      <= '0;
      conv     <= '0;
`endif
    end else begin
      state    <= state_n;
      k        <= k_n;
      cnt      <= cnt_n;
      dac_code <= dac_n;
      result   <= result_n;
`ifdef TATZEL_SAR_AVG_EN
      acc      <= acc_n;
      conv     <= conv_n;
`endif
    end
  end

  always_comb begin
    state_n     = state;
    k_n         = k;
    cnt_n       = cnt;
    dac_n       = dac_code;
    result_n    = result;
    dec_code    = dac_code;
    dec_code[k] = cmp_s;
`ifdef TATZEL_SAR_AVG_EN
    acc_n       = acc;
    conv_n      = conv;
    sum         = acc + {2'b00, dec_code};
`endif

    if (!sar.ena) begin
      state_n = IDLE;
      k_n     = '0;
      cnt_n   = '0;
      dac_n   = '0;
`ifdef TATZEL_SAR_AVG_EN
      acc_n   = '0;
      conv_n  = '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (sar.start) begin
            state_n = SETTLE;
            k_n     = K_MSB;
            cnt_n   = CNT_LOAD;
            dac_n   = MSB_CODE;
`ifdef TATZEL_SAR_AVG_EN
            acc_n   = '0;
            conv_n  = '0;
`endif
          end
        end

        SETTLE: begin
          if (cnt == '0) state_n = DECIDE;
          else           cnt_n   = cnt - 1'b1;
        end

        DECIDE: begin
          if (k != '0) begin
            dac_n          = dec_code;
            dac_n[k-1'b1]  = 1'b1;
            k_n            = k - 1'b1;
            cnt_n          = CNT_LOAD;
            state_n        = SETTLE;
          end else begin
`ifdef TATZEL_SAR_AVG_EN
            // Conversions 1-3 roll straight into the next MSB trial, no IDLE gap.
            if (conv != 2'd3) begin
              acc_n   = sum;
              conv_n  = conv + 1'b1;
              dac_n   = MSB_CODE;
              k_n     = K_MSB;
              cnt_n   = CNT_LOAD;
              state_n = SETTLE;
            end else begin
              result_n = sum[WIDTH+1:2];
              dac_n    = dec_code;
              acc_n    = '0;
              conv_n   = '0;
              state_n  = FINISH;
            end
`else
            // result is loaded on entry to FINISH so it is valid alongside done.
            result_n = dec_code;
            dac_n    = dec_code;
            state_n  = FINISH;
`endif
          end
        end

        FINISH:  state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  assign sar.dac_code = dac_code;
  assign sar.result   = result;
  assign sar.busy     = (state == SETTLE) || (state == DECIDE);
  assign sar.done     = (state == FINISH);

endmodule

// File: tb/tb_tatzel_sar_ctrl.sv
// Self-checking bench for tatzel_sar_ctrl: vector table plus hand-written corner sequences.
// Expected results are queued at start and compared when done is seen.
module tb_tatzel_sar_ctrl;

  localparam int W = 8;

  logic clk;
  logic rst_n;
  logic [1:0] mode;   // 0 ideal comparator, 1 tied high, 2 tied low
  logic [7:0] node;

  int n_checks = 0;
  int n_errs   = 0;
  logic [7:0] sb[$];
  logic [7:0] last_result;

  tatzel_sar_ctrl_if #(.WIDTH(W)) bus ();

  tatzel_sar_ctrl #(.WIDTH(W), .SETTLE_CYCLES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sar   (bus)
  );

  assign bus.cmp_in = (mode == 2'd0) ? (node >= bus.dac_code) : (mode == 2'd1);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] mode;
    logic [7:0] node;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic pop_and_check();
    logic [7:0] e;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 1, 0);
    end else begin
      e = sb.pop_front();
      check("result", bus.result, e);
      last_result = e;
    end
  endtask

  task automatic run_conv(input logic [1:0] m, input logic [7:0] nd, input logic [7:0] exp,
                          input bit repulse, input bit hold);
    int ndone;
    logic [7:0] code_m, trial, sh;
    ndone  = 0;
    code_m = 8'h00;
    sh     = 8'h80;
    mode   = m;
    node   = nd;
    sb.push_back(exp);
    bus.start = 1'b1;
    for (int c = 1; c <= 45; c++) begin
      @(posedge clk); #1;
      if (!hold) bus.start = repulse && (c == 10 || c == 20);
      if (m == 2'd0 && c <= 40 && ((c - 1) % 5) == 0) begin
        trial = code_m | (sh >> ((c - 1) / 5));
        check("trial", bus.dac_code, trial);
        if (nd >= trial) code_m = trial;
      end
      check("busy_and_done", bus.busy & bus.done, 0);
      if (bus.done) begin
        ndone++;
        check("done_cycle", c, 41);
        pop_and_check();
      end
      if (c == 42) begin
        check("busy_after_done", bus.busy, 0);
        check("done_width", bus.done, 0);
      end
      if (hold && c == 43) begin
        check("hold_restart_trial", bus.dac_code, 8'h80);
        check("hold_restart_busy", bus.busy, 1);
      end
      if (hold && c == 44) begin
        bus.start = 1'b0;
        bus.ena   = 1'b0;
      end
      if (hold && c == 45) begin
        check("hold_abort_dac", bus.dac_code, 0);
        check("hold_abort_busy", bus.busy, 0);
        bus.ena = 1'b1;
      end
    end
    check("done_count", ndone, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{2'd0, 8'hA5, 8'hA5};
    vecs[1] = '{2'd1, 8'h00, 8'hFF};
    vecs[2] = '{2'd2, 8'hFF, 8'h00};
    vecs[3] = '{2'd0, 8'h3C, 8'h3C};
    vecs[4] = '{2'd0, 8'h00, 8'h00};
    vecs[5] = '{2'd0, 8'hFF, 8'hFF};
    vecs[6] = '{2'd0, 8'h80, 8'h80};
    vecs[7] = '{2'd0, 8'h7F, 8'h7F};

    rst_n     = 1'b0;
    bus.ena   = 1'b1;
    bus.start = 1'b0;
    mode      = 2'd0;
    node      = 8'h00;
    last_result = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("reset_dac", bus.dac_code, 0);
    check("reset_result", bus.result, 0);
    check("reset_busy", bus.busy, 0);
    check("reset_done", bus.done, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

`ifdef TATZEL_SAR_AVG_EN
    begin
      int ndone;
      ndone = 0;
      sb.push_back(8'h41);
      node = 8'h40;
      bus.start = 1'b1;
      for (int c = 1; c <= 170; c++) begin
        @(posedge clk); #1;
        bus.start = 1'b0;
        node = (((c - 1) / 40) % 2) ? 8'h43 : 8'h40;
        check("busy_and_done", bus.busy & bus.done, 0);
        if (c == 41 || c == 81 || c == 121) check("avg_busy_between", bus.busy, 1);
        if (bus.done) begin
          ndone++;
          check("avg_done_cycle", c, 161);
          pop_and_check();
        end
      end
      check("avg_done_count", ndone, 1);
    end
`else
    for (int i = 0; i < 8; i++)
      run_conv(vecs[i].mode, vecs[i].node, vecs[i].exp, 1'b0, 1'b0);

    run_conv(2'd0, 8'h5A, 8'h5A, 1'b1, 1'b0);
    run_conv(2'd0, 8'hC3, 8'hC3, 1'b0, 1'b1);

    // ena dropped mid-conversion
    begin
      int ndone;
      ndone = 0;
      mode = 2'd0;
      node = 8'h3C;
      bus.start = 1'b1;
      for (int c = 1; c <= 45; c++) begin
        @(posedge clk); #1;
        bus.start = 1'b0;
        if (c == 14) check("ena_busy_before", bus.busy, 1);
        if (c == 15) bus.ena = 1'b0;
        if (c == 16) begin
          check("ena_dac_cleared", bus.dac_code, 0);
          check("ena_busy", bus.busy, 0);
          check("ena_result_kept", bus.result, last_result);
        end
        if (c == 17) bus.ena = 1'b1;
        if (bus.done) ndone++;
      end
      check("ena_no_done", ndone, 0);
    end

    // asynchronous reset mid-conversion
    mode = 2'd0;
    node = 8'h5A;
    bus.start = 1'b1;
    for (int c = 1; c <= 25; c++) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
    end
    check("pre_reset_busy", bus.busy, 1);
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_dac", bus.dac_code, 0);
    check("async_rst_result", bus.result, 0);
    check("async_rst_busy", bus.busy, 0);
    check("async_rst_done", bus.done, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_conv(2'd0, 8'hA5, 8'hA5, 1'b0, 1'b0);
`endif

    check("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
